save_state_slot_ctrl: RTL and testbench

Multi-slot successor to the single-image save-state controller. On a save or load request it waits for a system alignment point, where the CPU and PPU clock enables coincide. It then asserts the global stall and streams every state word between the state bus (CPU/PPU/memory save-data router) and a slot-partitioned backing memory. It supports NUM_SLOTS independent images, a configurable memory read latency, per-slot valid tracking, and error reporting for a load from an empty slot.

---
 rtl/svst_slot_pkg.sv | 27 ++
 rtl/save_state_slot_ctrl_if.sv | 33 +++
 rtl/svst_delay_pipe.sv | 54 +++++
 rtl/save_state_slot_ctrl.sv | 172 +++++++++++++++++
 tb/tb_save_state_slot_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/svst_slot_pkg.sv
// Shared types and constants for the multi-slot save-state controller.
// Holds the FSM/op enums and the SAVE_STATE address map used by clients.
package svst_slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ALIGN,
        XFER,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic {
        OP_SAVE,
        OP_LOAD
    } op_e;

    localparam int SAVE_STATE_ADDR_BITS = 12;
    localparam int SAVE_STATE_LAST_ADDR = 2100;
    localparam int SAVE_STATE_DATA_W    = 16;

    // Cycles between an issued address and its write-side strobe.
    function automatic int unsigned op_depth(op_e op, int unsigned mem_lat);
        return (op == OP_SAVE) ? 1 : mem_lat;
    endfunction

endpackage

// File: rtl/save_state_slot_ctrl_if.sv
// State-bus and backing-memory signals of the save-state controller.
// master: controller side; slave: router/memory side.
interface save_state_slot_ctrl_if
    import svst_slot_pkg::*;
#(
    parameter int ADDR_BITS = SAVE_STATE_ADDR_BITS,
    parameter int DATA_W    = SAVE_STATE_DATA_W,
    parameter int SLOT_BITS = 2
);
    logic                          state_read_en;
    logic                          state_write_en;
    logic [ADDR_BITS-1:0]          state_addr;
    logic [DATA_W-1:0]             state_write_data;
    logic [DATA_W-1:0]             state_read_data;
    logic                          mem_read_en;
    logic                          mem_write_en;
    logic [SLOT_BITS+ADDR_BITS-1:0] mem_addr;
    logic [DATA_W-1:0]             mem_write_data;
    logic [DATA_W-1:0]             mem_read_data;

    modport master (
        output state_read_en, state_write_en, state_addr, state_write_data,
        output mem_read_en, mem_write_en, mem_addr, mem_write_data,
        input  state_read_data, mem_read_data
    );

    modport slave (
        input  state_read_en, state_write_en, state_addr, state_write_data,
        input  mem_read_en, mem_write_en, mem_addr, mem_write_data,
        output state_read_data, mem_read_data
    );

endinterface

// File: rtl/svst_delay_pipe.sv
// Shift pipe carrying {valid, addr} with a runtime-selected output tap.
// Ports: clk, rst, valid_i/addr_i in, tap_i (1..DEPTH), valid_o/addr_o out.
module svst_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int AW    = 12,
    localparam int TAP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic             valid_o,
    output logic [AW-1:0]    addr_o
);

    // Bit AW of each entry is the valid flag.
    logic [AW:0] pipe_q [DEPTH];
    logic [AW:0] pipe_d [DEPTH];
    logic [AW:0] sel;

    always_comb begin
        pipe_d[0] = {valid_i, addr_i};
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Tap n returns the entry issued n cycles ago.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_i == TAP_W'(i + 1)) begin
                sel = pipe_q[i];
            end
        end
    end

    assign valid_o = sel[AW];
    assign addr_o  = sel[AW-1:0];

endmodule

// File: rtl/save_state_slot_ctrl.sv
// Multi-slot save-state controller: waits for alignment, stalls the system
// and streams all state words between the state bus and a slotted memory.
// Ports: clock/reset, begin_save/begin_load/slot requests, align, stall,
// busy, done, error, slot_valid status, bus (state + memory, master side).
module save_state_slot_ctrl
    import svst_slot_pkg::*;
#(
    parameter int ADDR_BITS = SAVE_STATE_ADDR_BITS,
    parameter int LAST_ADDR = SAVE_STATE_LAST_ADDR,
    parameter int DATA_W    = SAVE_STATE_DATA_W,
    parameter int NUM_SLOTS = 4,
    parameter int MEM_LAT   = 1,
    localparam int SLOT_BITS = $clog2(NUM_SLOTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 begin_save,
    input  logic                 begin_load,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 align,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_SLOTS-1:0] slot_valid,
    save_state_slot_ctrl_if.master bus
);

    localparam int TAP_W = $clog2(MEM_LAT + 1);

    state_e               state_q;
    op_e                  op_q;
    logic [SLOT_BITS-1:0] slot_q;
    logic [ADDR_BITS-1:0] cnt_q;
    logic [TAP_W-1:0]     drain_q;
    logic                 iss_q;
    logic                 stall_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [NUM_SLOTS-1:0] valid_q;

    logic [TAP_W-1:0]     tap;
    logic                 wr_v;
    logic [ADDR_BITS-1:0] wr_a;
    logic                 is_save;
    logic                 rd_save;
    logic                 rd_load;
    logic                 wr_save;
    logic                 wr_load;

    assign tap = TAP_W'(op_depth(op_q, MEM_LAT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_SAVE;
            slot_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            iss_q   <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            valid_q <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (begin_save) begin
                        op_q    <= OP_SAVE;
                        slot_q  <= slot;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_ALIGN;
                    end else if (begin_load) begin
                        if (valid_q[slot]) begin
                            op_q    <= OP_LOAD;
                            slot_q  <= slot;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_ALIGN;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                WAIT_ALIGN: begin
                    if (align) begin
                        state_q <= XFER;
                        stall_q <= 1'b1;
                        iss_q   <= 1'b1;
                        cnt_q   <= '0;
                        // An overwritten image is invalid until it completes.
                        if (op_q == OP_SAVE) begin
                            valid_q[slot_q] <= 1'b0;
                        end
                    end
                end
                XFER: begin
                    if (cnt_q == ADDR_BITS'(LAST_ADDR)) begin
                        iss_q   <= 1'b0;
                        drain_q <= tap - TAP_W'(1);
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (op_q == OP_SAVE) begin
                            valid_q[slot_q] <= 1'b1;
                        end
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    svst_delay_pipe #(
        .DEPTH (MEM_LAT),
        .AW    (ADDR_BITS)
    ) u_pipe (
        .clk     (clock),
        .rst     (reset),
        .valid_i (iss_q),
        .addr_i  (cnt_q),
        .tap_i   (tap),
        .valid_o (wr_v),
        .addr_o  (wr_a)
    );

    assign is_save = (op_q == OP_SAVE);
    assign rd_save = iss_q & is_save;
    assign rd_load = iss_q & ~is_save;
    assign wr_save = wr_v & is_save;
    assign wr_load = wr_v & ~is_save;

    assign bus.state_read_en  = rd_save;
    assign bus.mem_read_en    = rd_load;
    assign bus.mem_write_en   = wr_save;
    assign bus.state_write_en = wr_load;

    assign bus.state_addr = rd_save ? cnt_q :
                            wr_load ? wr_a  : '0;
    assign bus.mem_addr   = rd_load ? {slot_q, cnt_q} :
                            wr_save ? {slot_q, wr_a}  : '0;

    // Data is forwarded on the cycle it arrives, alongside the delayed strobe.
    assign bus.mem_write_data   = wr_save ? bus.state_read_data
                                          : {DATA_W{1'b0}};
    assign bus.state_write_data = wr_load ? bus.mem_read_data
                                          : {DATA_W{1'b0}};

    assign stall      = stall_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign slot_valid = valid_q;

endmodule

// File: tb/tb_save_state_slot_ctrl.sv
// Directed bench for save_state_slot_ctrl with router/memory models
// and a scoreboard of expected write-side transfers.
module tb_save_state_slot_ctrl;

    localparam int AB = 12;
    localparam int LA = 7;
    localparam int DW = 16;
    localparam int NS = 4;
    localparam int ML = 2;
    localparam int SB = 2;
    localparam int AW = SB + AB;
    localparam int N  = LA + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          begin_save;
    logic          begin_load;
    logic          align;
    logic [SB-1:0] slot;
    logic          stall;
    logic          busy;
    logic          done;
    logic          error;
    logic [NS-1:0] slot_valid;

    save_state_slot_ctrl_if #(
        .ADDR_BITS (AB),
        .DATA_W    (DW),
        .SLOT_BITS (SB)
    ) bus ();

    save_state_slot_ctrl #(
        .ADDR_BITS (AB),
        .LAST_ADDR (LA),
        .DATA_W    (DW),
        .NUM_SLOTS (NS),
        .MEM_LAT   (ML)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .begin_save (begin_save),
        .begin_load (begin_load),
        .slot       (slot),
        .align      (align),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .slot_valid (slot_valid),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;

    logic [DW-1:0] seed = 16'hA500;

    typedef struct {
        logic          is_mem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Router: returns seed^addr one cycle after a read strobe.
    logic [DW-1:0] rtr_q = '0;
    always @(posedge clk) begin
        rtr_q <= bus.state_read_en ? (seed ^ DW'(bus.state_addr)) : '0;
    end
    assign bus.state_read_data = rtr_q;

    // Backing memory with ML-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_p1 = '0;
    logic [DW-1:0] rd_p2 = '0;
    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            mem[bus.mem_addr] <= bus.mem_write_data;
        end
        rd_p1 <= bus.mem_read_en ? mem[bus.mem_addr] : '0;
        rd_p2 <= rd_p1;
    end
    assign bus.mem_read_data = rd_p2;

    // Monitor on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (bus.state_read_en | bus.state_write_en |
            bus.mem_read_en | bus.mem_write_en) begin
            strobe_cnt++;
        end
        if (bus.state_read_en | bus.state_write_en) begin
            chk("state_rw_excl", 32'(bus.state_read_en & bus.state_write_en), 0);
        end
        if (bus.mem_read_en | bus.mem_write_en) begin
            chk("mem_rw_excl", 32'(bus.mem_read_en & bus.mem_write_en), 0);
        end
        if (bus.mem_write_en === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("mem_wr_unexpected", 32'(sbq.size()), 1);
            end else begin
                e = sbq.pop_front();
                chk("mem_wr_kind", 32'(e.is_mem), 1);
                chk("mem_wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("mem_wr_data", 32'(bus.mem_write_data), 32'(e.data));
            end
        end
        if (bus.state_write_en === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("st_wr_unexpected", 32'(sbq.size()), 1);
            end else begin
                e = sbq.pop_front();
                chk("st_wr_kind", 32'(e.is_mem), 0);
                chk("st_wr_addr", 32'(bus.state_addr), 32'(e.addr));
                chk("st_wr_data", 32'(bus.state_write_data), 32'(e.data));
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_cnt  = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        strobe_cnt = 0;
    endtask

    task automatic push_save(int s, logic [DW-1:0] sd);
        exp_t x;
        for (int k = 0; k < N; k++) begin
            x.is_mem = 1'b1;
            x.addr   = {SB'(s), AB'(k)};
            x.data   = sd ^ DW'(k);
            sbq.push_back(x);
        end
    endtask

    task automatic push_load(logic [DW-1:0] sd);
        exp_t x;
        for (int k = 0; k < N; k++) begin
            x.is_mem = 1'b0;
            x.addr   = AW'(k);
            x.data   = sd ^ DW'(k);
            sbq.push_back(x);
        end
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step(1);
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
    endtask

    task automatic do_save(int s, logic [DW-1:0] sd);
        clr();
        seed = sd;
        push_save(s, sd);
        slot = SB'(s);
        begin_save = 1'b1;
        step(1);
        begin_save = 1'b0;
        wait_done(100);
        step(2);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        begin_save = 1'b0;
        begin_load = 1'b0;
        align = 1'b0;
        slot = '0;
        step(3);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_valid", 32'(slot_valid), 0);
        chk("rst_rd_en", 32'(bus.state_read_en), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        rst = 1'b0;
        step(1);

        // Load from an empty slot.
        clr();
        slot = 2'd1;
        begin_load = 1'b1;
        step(1);
        begin_load = 1'b0;
        chk("err_pulse", 32'(error), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_stall", 32'(stall), 0);
        step(1);
        chk("err_one_cycle", 32'(error), 0);
        step(3);
        chk("err_count", 32'(err_cnt), 1);
        chk("err_no_strobe", 32'(strobe_cnt), 0);
        chk("err_no_stall", 32'(stall_cnt), 0);

        // Save to slot 2, align rises 3 cycles after the request.
        clr();
        seed = 16'hA500;
        push_save(2, 16'hA500);
        slot = 2'd2;
        begin_save = 1'b1;
        step(1);
        begin_save = 1'b0;
        chk("sv_busy", 32'(busy), 1);
        chk("sv_stall0", 32'(stall), 0);
        step(2);
        align = 1'b1;
        wait_done(100);
        step(2);
        chk("sv_stall_cycles", 32'(stall_cnt), 10);
        chk("sv_done_once", 32'(done_cnt), 1);
        chk("sv_valid", 32'(slot_valid), 32'h4);
        chk("sv_sb_empty", 32'(sbq.size()), 0);
        chk("sv_idle", 32'(busy | stall), 0);
        for (int k = 0; k < N; k++) begin
            chk("sv_mem", 32'(mem[{2'd2, AB'(k)}]), 32'(16'hA500 ^ DW'(k)));
        end

        // Load slot 2 back while the router shows other data.
        clr();
        seed = 16'h5A00;
        push_load(16'hA500);
        slot = 2'd2;
        begin_load = 1'b1;
        step(1);
        begin_load = 1'b0;
        wait_done(100);
        step(2);
        chk("ld_stall_cycles", 32'(stall_cnt), 11);
        chk("ld_done_once", 32'(done_cnt), 1);
        chk("ld_no_error", 32'(err_cnt), 0);
        chk("ld_sb_empty", 32'(sbq.size()), 0);
        chk("ld_valid", 32'(slot_valid), 32'h4);

        // Simultaneous save+load: save wins; a load during busy is dropped.
        clr();
        seed = 16'h3C00;
        push_save(0, 16'h3C00);
        slot = 2'd0;
        begin_save = 1'b1;
        begin_load = 1'b1;
        step(1);
        begin_save = 1'b0;
        begin_load = 1'b0;
        step(2);
        slot = 2'd2;
        begin_load = 1'b1;
        step(1);
        begin_load = 1'b0;
        wait_done(100);
        step(5);
        chk("both_done_once", 32'(done_cnt), 1);
        chk("both_stall", 32'(stall_cnt), 10);
        chk("both_valid", 32'(slot_valid), 32'h5);
        chk("both_sb_empty", 32'(sbq.size()), 0);
        chk("both_not_busy", 32'(busy), 0);

        // Fill slot 3, then abort a second save to it with reset.
        do_save(3, 16'h1200);
        chk("s3_valid", 32'(slot_valid), 32'hD);
        chk("s3_sb_empty", 32'(sbq.size()), 0);
        clr();
        seed = 16'h7700;
        push_save(3, 16'h7700);
        slot = 2'd3;
        begin_save = 1'b1;
        step(1);
        begin_save = 1'b0;
        step(4);
        chk("ab_in_xfer", 32'(stall), 1);
        chk("ab_valid_clr", 32'(slot_valid), 32'h5);
        rst = 1'b1;
        step(1);
        chk("ab_stall", 32'(stall), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(slot_valid), 0);
        rst = 1'b0;
        sbq.delete();
        step(1);
        do_save(3, 16'h6600);
        chk("rs_stall", 32'(stall_cnt), 10);
        chk("rs_done", 32'(done_cnt), 1);
        chk("rs_valid", 32'(slot_valid), 32'h8);
        chk("rs_sb_empty", 32'(sbq.size()), 0);

        // Align held low for 50 cycles.
        align = 1'b0;
        clr();
        seed = 16'h4400;
        push_save(1, 16'h4400);
        slot = 2'd1;
        begin_save = 1'b1;
        step(1);
        begin_save = 1'b0;
        bad = 0;
        repeat (50) begin
            if (!(busy === 1'b1 && stall === 1'b0)) bad++;
            step(1);
        end
        chk("wa_hold", 32'(bad), 0);
        chk("wa_no_strobe", 32'(strobe_cnt), 0);
        chk("wa_no_stall", 32'(stall_cnt), 0);
        align = 1'b1;
        chk("wa_edge_rd", 32'(bus.state_read_en), 0);
        chk("wa_edge_stall", 32'(stall), 0);
        step(1);
        chk("wa_start_stall", 32'(stall), 1);
        chk("wa_start_rd", 32'(bus.state_read_en), 1);
        chk("wa_start_addr", 32'(bus.state_addr), 0);
        wait_done(100);
        step(2);
        chk("wa_stall_cycles", 32'(stall_cnt), 10);
        chk("wa_valid", 32'(slot_valid), 32'hA);
        chk("wa_sb_empty", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
